// File: rtl/shift_pkg.sv
// shift_pkg: shared widths and shift-type encodings for the shift unit
package shift_pkg;
   localparam int SH_DW = 32;
   localparam int SH_AW = 5;
   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_RSV = 2'b11
   } shType_e;
endpackage

// File: rtl/shift_unit_if.sv
// shift_unit_if: request and result valid/ready channels of the shift unit
interface shift_unit_if;
   import shift_pkg::*;
   logic             InValid;
   logic             InReady;
   logic [SH_DW-1:0] ShIn;
   logic [SH_AW-1:0] Shamt;
   shType_e          ShType;
   logic             OutValid;
   logic             OutReady;
   logic [SH_DW-1:0] ShOut;
   logic             ZeroFlag;
   logic             CarryOut;
   logic             IllegalOp;
   modport master (
      output InValid, ShIn, Shamt, ShType, OutReady,
      input  InReady, OutValid, ShOut, ZeroFlag, CarryOut, IllegalOp
   );
   modport slave (
      input  InValid, ShIn, Shamt, ShType, OutReady,
      output InReady, OutValid, ShOut, ZeroFlag, CarryOut, IllegalOp
   );
endinterface

// File: rtl/shift_core.sv
// shift_core: combinational LSL/LSR/ASR select with last-bit-out carry and reserved-type detect.
// The carry datapath exists only when SHIFT_CARRY_EN is defined.
module shift_core
   import shift_pkg::*;
(
   input  logic [SH_DW-1:0] shIn,
   input  logic [SH_AW-1:0] shamt,
   input  shType_e          shType,
   output logic [SH_DW-1:0] shOut,
   output logic             carry,
   output logic             illegal
);
   logic [SH_DW-1:0] lslRes, lsrRes, asrRes;
   logic             lslC, lsrC, asrC;
`ifdef SHIFT_CARRY_EN
   // One guard bit on the exit side captures the last bit shifted out
   assign {lslC, lslRes} = {1'b0, shIn} << shamt;
   assign {lsrRes, lsrC} = {shIn, 1'b0} >> shamt;
   assign {asrRes, asrC} = $signed({shIn, 1'b0}) >>> shamt;
`else
   assign lslRes = shIn << shamt;
   assign lsrRes = shIn >> shamt;
   assign asrRes = $signed(shIn) >>> shamt;
   assign {lslC, lsrC, asrC} = '0;
`endif
   always_comb begin
      shOut   = shType == SH_LSL ? lslRes : shType == SH_LSR ? lsrRes : shType == SH_ASR ? asrRes : shIn;
      carry   = shType == SH_LSL ? lslC : shType == SH_LSR ? lsrC : shType == SH_ASR ? asrC : 1'b0;
      illegal = shType == SH_RSV;
   end
endmodule

// File: rtl/shift_unit.sv
// shift_unit: two-stage valid/ready shift pipeline (operand stage S1, result stage S2).
// Define SHIFT_CARRY_EN to compute and register CarryOut; otherwise CarryOut is tied to 0.
module shift_unit
   import shift_pkg::*;
(
   input logic         CLK,
   input logic         RESETn,
   input logic         Flush,
   shift_unit_if.slave bus
);
   logic             s1Valid, s2Valid, s1Adv, s2Adv, inFire, s2Load;
   logic [SH_DW-1:0] s1Data, coreOut;
   logic [SH_AW-1:0] s1Shamt;
   shType_e          s1Type;
   logic             coreCarry, coreIllegal;
   assign s2Adv        = !s2Valid || bus.OutReady;
   assign s1Adv        = !s1Valid || s2Adv;
   assign bus.InReady  = s1Adv && !Flush;
   assign inFire       = bus.InValid && bus.InReady;
   assign s2Load       = s2Adv && s1Valid && !Flush;
   assign bus.OutValid = s2Valid;
   shift_core core (
      .shIn(s1Data), .shamt(s1Shamt), .shType(s1Type),
      .shOut(coreOut), .carry(coreCarry), .illegal(coreIllegal)
   );
   // Flush overrides any transfer happening on the same edge
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
      end else begin
         s1Valid <= !Flush && (s1Adv ? bus.InValid : s1Valid);
         s2Valid <= !Flush && (s2Adv ? s1Valid : s2Valid);
      end
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         s1Data  <= '0;
         s1Shamt <= '0;
         s1Type  <= SH_LSL;
      end else if (inFire) begin
         s1Data  <= bus.ShIn;
         s1Shamt <= bus.Shamt;
         s1Type  <= bus.ShType;
      end
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         bus.ShOut     <= '0;
         bus.ZeroFlag  <= 1'b0;
         bus.IllegalOp <= 1'b0;
      end else if (s2Load) begin
         bus.ShOut     <= coreOut;
         bus.ZeroFlag  <= coreOut == '0;
         bus.IllegalOp <= coreIllegal;
      end
`ifdef SHIFT_CARRY_EN
   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn)
         bus.CarryOut <= 1'b0;
      else if (s2Load)
         bus.CarryOut <= coreCarry;
`else
   assign bus.CarryOut = coreCarry;
`endif
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: self-checking bench for shift_unit against an arithmetic reference model.
// Expected CarryOut follows SHIFT_CARRY_EN.
module tb_shift_unit;
   import shift_pkg::*;
`ifdef SHIFT_CARRY_EN
   localparam bit CarryEn = 1'b1;
`else
   localparam bit CarryEn = 1'b0;
`endif
   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   logic Flush = 1'b0;
   int   total = 0;
   int   bad = 0;
   shift_unit_if bus ();
   shift_unit dut (.CLK(CLK), .RESETn(RESETn), .Flush(Flush), .bus(bus));
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] out;
      logic        c;
      logic        z;
      logic        ill;
   } exp_t;

   // Reference: shifts as multiply/divide by powers of two, sign fill added as a constant
   function automatic exp_t model(input logic [31:0] x, input int amt, input int typ);
      exp_t e;
      longint unsigned xl = 64'(x);
      longint unsigned p = 64'd1 << amt;
      longint unsigned wrap = 64'h1_0000_0000;
      e.ill = typ == 3;
      e.c = 1'b0;
      if (typ == 0) begin
         e.out = 32'((xl * p) % wrap);
         e.c = ((xl * p) / wrap) % 2 == 1;
      end else if (typ == 1 || typ == 2) begin
         e.out = 32'(xl / p + ((typ == 2 && x[31]) ? wrap - wrap / p : 64'd0));
         if (amt != 0) e.c = (xl / (p / 2)) % 2 == 1;
      end else
         e.out = x;
      e.c = e.c & CarryEn;
      e.z = e.out == 0;
      return e;
   endfunction

   task automatic drive(input logic [31:0] x, input int amt, input int typ);
      bus.ShIn = x;
      bus.Shamt = 5'(amt);
      bus.ShType = shType_e'(typ[1:0]);
   endtask

   task automatic test_reset();
      bus.InValid = 0;
      bus.OutReady = 1;
      drive(0, 0, 0);
      RESETn = 0;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if ({bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== 36'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp});
      end
      @(negedge CLK) RESETn = 1;
      #1;
      total++;
      if (bus.InReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_inready got=%b want=1", bus.InReady);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vx[4], vo[4];
      int va[4], vt[4];
      logic vc[4], vz[4];
      vx = '{32'h80000000, 32'h80000001, 32'h00000001, 32'hFFFFFFFF};
      va = '{4, 1, 1, 31};
      vt = '{2, 0, 1, 2};
      vo = '{32'hF8000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
      vc = '{1'b0, 1'b1, 1'b1, 1'b1};
      vz = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         drive(vx[i], va[i], vt[i]);
         bus.InValid = 1;
         bus.OutReady = 1;
         @(negedge CLK);
         total++;
         if (bus.InReady !== 1'b1) begin
            bad++;
            $display("FAIL dir%0d_accept got=%b want=1", i, bus.InReady);
         end
         @(posedge CLK);
         #1;
         bus.InValid = 0;
         total++;
         if (bus.OutValid !== 1'b0) begin
            bad++;
            $display("FAIL dir%0d_early got=%b want=0", i, bus.OutValid);
         end
         @(posedge CLK);
         #1;
         total++;
         if ({bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== {1'b1, vo[i], vz[i], vc[i] & CarryEn, 1'b0}) begin
            bad++;
            $display("FAIL dir%0d_result got=%h want=%h", i, {bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp},
                     {1'b1, vo[i], vz[i], vc[i] & CarryEn, 1'b0});
         end
         @(posedge CLK);
         #1;
         total++;
         if (bus.OutValid !== 1'b0) begin
            bad++;
            $display("FAIL dir%0d_consumed got=%b want=0", i, bus.OutValid);
         end
      end
   endtask

   task automatic test_illegal();
      @(posedge CLK);
      #1;
      drive(32'h12345678, $urandom_range(0, 31), 3);
      bus.InValid = 1;
      bus.OutReady = 1;
      @(posedge CLK);
      #1;
      bus.InValid = 0;
      @(posedge CLK);
      #1;
      total++;
      if ({bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL illegal_result got=%h want=%h", {bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp},
                  {1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1});
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] x[8];
      int a[8], t[8];
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, cyc = 0;
      bit sawLow = 0, acc;
      for (int i = 0; i < 8; i++) begin
         x[i] = $urandom;
         a[i] = $urandom_range(0, 31);
         t[i] = $urandom_range(0, 2);
      end
      @(posedge CLK);
      #1;
      while (got < 8 && cyc < 60) begin
         bus.OutReady = !(cyc >= 4 && cyc <= 6);
         bus.InValid = sent < 8;
         if (sent < 8) drive(x[sent], a[sent], t[sent]);
         @(negedge CLK);
         if (bus.InValid) begin
            total++;
            if (bus.InReady !== !((sent - got) == 2 && !bus.OutReady)) begin
               bad++;
               $display("FAIL b2b_inready cyc=%0d got=%b", cyc, bus.InReady);
            end
            if (!bus.InReady) sawLow = 1;
         end
         if (bus.OutValid && bus.OutReady) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL b2b_extra got=%h want=none", bus.ShOut);
            end else begin
               e = q.pop_front();
               if ({bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== {e.out, e.z, e.c, e.ill}) begin
                  bad++;
                  $display("FAIL b2b_data%0d got=%h want=%h", got, {bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp},
                           {e.out, e.z, e.c, e.ill});
               end
            end
            got++;
         end
         acc = bus.InValid && bus.InReady;
         @(posedge CLK);
         #1;
         if (acc) begin
            q.push_back(model(x[sent], a[sent], t[sent]));
            sent++;
         end
         cyc++;
      end
      bus.InValid = 0;
      total++;
      if (got != 8 || !sawLow) begin
         bad++;
         $display("FAIL b2b_count got=%0d stall=%0b want=8 stall=1", got, sawLow);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         total++;
         if (bus.OutValid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_dup got=%b want=0", bus.OutValid);
         end
      end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      logic [31:0] x, prevOut;
      int a, t, sent = 0, got = 0, cyc = 0;
      bit acc = 1, prevStall = 0;
      while ((sent < 40 || got < sent) && cyc < 2000) begin
         if (acc || !bus.InValid) begin
            x = $urandom;
            a = $urandom_range(0, 31);
            t = $urandom_range(0, 3);
            drive(x, a, t);
            bus.InValid = sent < 40 && $urandom_range(0, 3) != 0;
         end
         bus.OutReady = $urandom_range(0, 2) != 0;
         @(negedge CLK);
         if (prevStall) begin
            total++;
            if (bus.OutValid !== 1'b1 || bus.ShOut !== prevOut) begin
               bad++;
               $display("FAIL rnd_hold got=%b/%h want=1/%h", bus.OutValid, bus.ShOut, prevOut);
            end
         end
         if (bus.InValid) begin
            total++;
            if (bus.InReady !== !((sent - got) == 2 && !bus.OutReady)) begin
               bad++;
               $display("FAIL rnd_inready cyc=%0d got=%b", cyc, bus.InReady);
            end
         end
         if (bus.OutValid && bus.OutReady) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rnd_extra got=%h want=none", bus.ShOut);
            end else begin
               e = q.pop_front();
               if ({bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== {e.out, e.z, e.c, e.ill}) begin
                  bad++;
                  $display("FAIL rnd_data%0d got=%h want=%h", got, {bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp},
                           {e.out, e.z, e.c, e.ill});
               end
            end
            got++;
         end
         prevStall = bus.OutValid && !bus.OutReady;
         prevOut = bus.ShOut;
         acc = bus.InValid && bus.InReady;
         @(posedge CLK);
         #1;
         if (acc) begin
            q.push_back(model(x, a, t));
            sent++;
         end
         cyc++;
      end
      bus.InValid = 0;
      bus.OutReady = 1;
      total++;
      if (sent != 40 || got != 40) begin
         bad++;
         $display("FAIL rnd_count sent=%0d got=%0d want=40", sent, got);
      end
   endtask

   task automatic test_flush();
      exp_t e;
      @(posedge CLK);
      #1;
      bus.OutReady = 0;
      bus.InValid = 1;
      drive(32'h0000F000, 4, 1);
      @(posedge CLK);
      #1;
      drive(32'h00000003, 2, 0);
      @(posedge CLK);
      #1;
      total++;
      if (bus.OutValid !== 1'b1) begin
         bad++;
         $display("FAIL flush_prefill got=%b want=1", bus.OutValid);
      end
      drive(32'hDEADBEEF, 8, 2);
      Flush = 1;
      @(negedge CLK);
      total++;
      if (bus.InReady !== 1'b0) begin
         bad++;
         $display("FAIL flush_inready got=%b want=0", bus.InReady);
      end
      @(posedge CLK);
      #1;
      Flush = 0;
      bus.InValid = 0;
      bus.OutReady = 1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (bus.OutValid !== 1'b0) begin
            bad++;
            $display("FAIL flush_killed%0d got=%b want=0", i, bus.OutValid);
         end
         @(posedge CLK);
         #1;
      end
      e = model(32'hA5A5A5A5, 7, 0);
      drive(32'hA5A5A5A5, 7, 0);
      bus.InValid = 1;
      @(posedge CLK);
      #1;
      bus.InValid = 0;
      @(posedge CLK);
      #1;
      total++;
      if ({bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== {1'b1, e.out, e.z, e.c, e.ill}) begin
         bad++;
         $display("FAIL flush_next got=%h want=%h", {bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp},
                  {1'b1, e.out, e.z, e.c, e.ill});
      end
      @(posedge CLK);
      #1;
      total++;
      if (bus.OutValid !== 1'b0) begin
         bad++;
         $display("FAIL flush_after got=%b want=0", bus.OutValid);
      end
   endtask

   task automatic test_async_reset();
      @(posedge CLK);
      #1;
      bus.OutReady = 0;
      bus.InValid = 1;
      drive(32'h00000001, 3, 0);
      @(posedge CLK);
      #1;
      drive(32'h80000000, 1, 2);
      @(posedge CLK);
      #1;
      bus.InValid = 0;
      total++;
      if (bus.OutValid !== 1'b1 || bus.ShOut !== 32'h8) begin
         bad++;
         $display("FAIL arst_pre got=%b/%h want=1/00000008", bus.OutValid, bus.ShOut);
      end
      #2;
      RESETn = 0;
      #1;
      total++;
      if ({bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp} !== 36'h0) begin
         bad++;
         $display("FAIL arst_now got=%h want=0", {bus.OutValid, bus.ShOut, bus.ZeroFlag, bus.CarryOut, bus.IllegalOp});
      end
      @(negedge CLK);
      RESETn = 1;
      bus.OutReady = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK);
         #1;
         total++;
         if (bus.OutValid !== 1'b0) begin
            bad++;
            $display("FAIL arst_stale%0d got=%b want=0", i, bus.OutValid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_back_to_back();
      test_random();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
